// File: rtl/mem_access_unit_pkg.sv
// mem_pkg: shared state encoding and sizing for the MIPS data-memory access unit.
// Revision 1.0
`default_nettype none

package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mau_state_t;

  localparam int TIMEOUT_DEFAULT = 16;
  localparam int TOW = $clog2(TIMEOUT_DEFAULT);

  function automatic logic is_word_aligned(input logic [1:0] lsb);
    return (lsb == 2'b00);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_access_unit_timeout_ctr.sv
// timeout_ctr: bus wait-cycle counter, flags the last permitted BUSY cycle.
// Revision 1.0
`default_nettype none

module timeout_ctr #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (count == CW'(TIMEOUT - 1));

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// mem_access_unit: turns single-cycle lw/sw into a req/ack bus transaction, stalling the datapath meanwhile.
// Revision 1.0
`default_nettype none

module mem_access_unit
  import mem_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          memread,
  input  logic          memwrite,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          stall,
  output logic          bus_req,
  output logic          bus_we,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  input  logic          bus_ack,
  input  logic [DW-1:0] bus_rdata,
  output logic          err_align,
  output logic          err_timeout
);

  mau_state_t state;
  mau_state_t state_next;
  logic       access;
  logic       aligned;
  logic       expired;

  assign access  = memread | memwrite;
  assign aligned = is_word_aligned(addr[1:0]);

  timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout_ctr (
    .clk     (clk),
    .reset   (reset),
    .clear   (state != BUSY),
    .enable  ((state == BUSY) && !bus_ack),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    stall      = 1'b0;
    case (state)
      IDLE: begin
        if (access) begin
          stall      = 1'b1;
          state_next = aligned ? BUSY : DONE;
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (bus_ack || expired) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign bus_req = (state == BUSY);

  // Bus-side bank is loaded once at launch so it stays stable for the whole BUSY window.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_we    <= 1'b0;
    end else if ((state == IDLE) && access && aligned) begin
      bus_addr  <= addr;
      bus_wdata <= wdata;
      bus_we    <= memwrite;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata       <= '0;
      err_align   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      if ((state == IDLE) && access && !aligned) begin
        err_align <= 1'b1;
        rdata     <= '0;
      end
      // An ack arriving on the last permitted cycle takes priority over the timeout.
      if (state == BUSY) begin
        if (bus_ack) begin
          if (!bus_we) begin
            rdata <= bus_rdata;
          end
        end else if (expired) begin
          err_timeout <= 1'b1;
          rdata       <= '0;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: transaction-level model of mem_access_unit with directed and random instruction streams.
// Revision 1.0
`default_nettype none

module tb_mem_access_unit;

  localparam int TIMEOUT = 16;

  logic        clk;
  logic        reset;
  logic        memread;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        err_align;
  logic        err_timeout;

  mem_access_unit #(.AW(32), .DW(32), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .reset       (reset),
    .memread     (memread),
    .memwrite    (memwrite),
    .addr        (addr),
    .wdata       (wdata),
    .rdata       (rdata),
    .stall       (stall),
    .bus_req     (bus_req),
    .bus_we      (bus_we),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_ack     (bus_ack),
    .bus_rdata   (bus_rdata),
    .err_align   (err_align),
    .err_timeout (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        req;
    logic        chk_bus;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ea;
    logic        et;
  } exp_t;

  exp_t        q[$];
  int          n_cmp    = 0;
  int          n_bad    = 0;
  int          stall_cnt = 0;
  int          req_cnt  = 0;
  int          req_rise = 0;
  logic        prev_req = 1'b0;
  logic [31:0] m_rdata  = '0;
  logic        m_ea     = 1'b0;
  logic        m_et     = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model expectations are pushed by the driver one cycle at a time and checked mid-cycle.
  always @(negedge clk) begin : cmp
    exp_t e;
    if (reset) begin
      stall_cnt += int'(stall);
      req_cnt   += int'(bus_req);
      if (bus_req && !prev_req) req_rise++;
      prev_req = bus_req;
    end else begin
      prev_req = 1'b0;
    end
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("stall", 32'(stall), 32'(e.stall));
      chk("bus_req", 32'(bus_req), 32'(e.req));
      chk("rdata", rdata, e.rdata);
      chk("err_align", 32'(err_align), 32'(e.ea));
      chk("err_timeout", 32'(err_timeout), 32'(e.et));
      if (e.chk_bus) begin
        chk("bus_we", 32'(bus_we), 32'(e.we));
        chk("bus_addr", bus_addr, e.addr);
        chk("bus_wdata", bus_wdata, e.wdata);
      end
    end
  end

  task automatic push(input logic st, input logic rq, input logic cb, input logic we_,
                      input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    e.stall = st; e.req = rq; e.chk_bus = cb; e.we = we_;
    e.addr = a; e.wdata = wd; e.rdata = m_rdata; e.ea = m_ea; e.et = m_et;
    q.push_back(e);
  endtask

  function automatic logic spur();
    return ($urandom_range(0, 3) == 0);
  endfunction

  // ack_at: BUSY cycle index (0-based) carrying the ack; negative or >= TIMEOUT means no ack.
  task automatic run_instr(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] wd, input int ack_at, input logic [31:0] brd);
    logic is_mem;
    logic mis;
    logic acked;
    int   nb;
    is_mem = rd | wr;
    mis    = (a[1:0] != 2'b00);
    acked  = (ack_at >= 0) && (ack_at < TIMEOUT);
    memread = rd; memwrite = wr; addr = a; wdata = wd;
    bus_ack = spur(); bus_rdata = $urandom;
    if (!is_mem) begin
      push(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
      @(posedge clk); #1;
      return;
    end
    push(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    @(posedge clk); #1;
    if (mis) begin
      m_ea = 1'b1;
      m_rdata = '0;
    end else begin
      nb = acked ? ack_at + 1 : TIMEOUT;
      for (int i = 0; i < nb; i++) begin
        bus_ack   = (i == ack_at);
        bus_rdata = (i == ack_at) ? brd : $urandom;
        addr      = $urandom;
        wdata     = $urandom;
        push(1'b1, 1'b1, 1'b1, wr, a, wd);
        @(posedge clk); #1;
      end
      if (!acked) begin
        m_et = 1'b1;
        m_rdata = '0;
      end else if (!wr) begin
        m_rdata = brd;
      end
    end
    bus_ack = spur(); bus_rdata = $urandom;
    push(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    @(posedge clk); #1;
  endtask

  task automatic clr_counts();
    stall_cnt = 0; req_cnt = 0; req_rise = 0;
  endtask

  initial begin
    logic [31:0] ra;
    int          ack;
    reset = 1'b0; memread = 1'b0; memwrite = 1'b0; addr = '0; wdata = '0;
    bus_ack = 1'b0; bus_rdata = '0;
    #2;
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_bus_req", 32'(bus_req), 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_err", {30'h0, err_align, err_timeout}, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // 1: load, ack in first BUSY cycle
    clr_counts();
    run_instr(1'b1, 1'b0, 32'h0000_0040, 32'h1111_2222, 0, 32'h1234_5678);
    chk("t1_stall_cycles", stall_cnt, 2);
    chk("t1_rdata", rdata, 32'h1234_5678);
    chk("t1_bus_we", 32'(bus_we), 32'h0);

    // 2: store, ack in 5th BUSY cycle
    clr_counts();
    run_instr(1'b0, 1'b1, 32'h0000_0080, 32'hCAFE_F00D, 4, 32'hDEAD_BEEF);
    chk("t2_stall_cycles", stall_cnt, 6);
    chk("t2_req_cycles", req_cnt, 5);
    chk("t2_rdata_kept", rdata, 32'h1234_5678);
    chk("t2_bus_addr", bus_addr, 32'h0000_0080);
    chk("t2_bus_wdata", bus_wdata, 32'hCAFE_F00D);

    // 3: misaligned load
    clr_counts();
    run_instr(1'b1, 1'b0, 32'h0000_0042, 32'h0, 0, 32'hFFFF_FFFF);
    chk("t3_stall_cycles", stall_cnt, 1);
    chk("t3_req_cycles", req_cnt, 0);
    chk("t3_err_align", 32'(err_align), 32'h1);
    chk("t3_rdata", rdata, 32'h0);

    // 5: ack on the last permitted cycle wins over timeout
    clr_counts();
    run_instr(1'b1, 1'b0, 32'h0000_0100, 32'h0, TIMEOUT - 1, 32'hA5A5_0001);
    chk("t5_req_cycles", req_cnt, 16);
    chk("t5_rdata", rdata, 32'hA5A5_0001);
    chk("t5_no_timeout", 32'(err_timeout), 32'h0);

    // 4: no ack at all
    clr_counts();
    run_instr(1'b1, 1'b0, 32'h0000_0104, 32'h0, -1, 32'h0);
    chk("t4_req_cycles", req_cnt, 16);
    chk("t4_stall_cycles", stall_cnt, 17);
    chk("t4_err_timeout", 32'(err_timeout), 32'h1);
    chk("t4_rdata", rdata, 32'h0);

    // Spurious ack while idle, then back-to-back lw/sw
    clr_counts();
    memread = 1'b0; memwrite = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h5555_AAAA;
    push(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    @(posedge clk); #1;
    run_instr(1'b1, 1'b0, 32'h0000_0200, 32'h0, 1, 32'h0BAD_F00D);
    run_instr(1'b0, 1'b1, 32'h0000_0204, 32'h7777_8888, 2, 32'h0);
    chk("b2b_transactions", req_rise, 2);
    chk("b2b_rdata", rdata, 32'h0BAD_F00D);

    // Randomized instruction stream
    for (int n = 0; n < 80; n++) begin
      ra = $urandom;
      if ($urandom_range(0, 7) != 0) ra[1:0] = 2'b00;
      ack = ($urandom_range(0, 3) != 0) ? int'($urandom_range(0, 3))
                                        : int'($urandom_range(0, TIMEOUT + 3));
      run_instr(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, $urandom, ack, $urandom);
    end

    // 6: reset in the middle of a BUSY window
    memread = 1'b1; memwrite = 1'b0; addr = 32'h0000_0300; bus_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #3;
    chk("t6_req_before", 32'(bus_req), 32'h1);
    reset = 1'b0;
    #1;
    chk("t6_req_async", 32'(bus_req), 32'h0);
    chk("t6_rdata", rdata, 32'h0);
    chk("t6_err", {30'h0, err_align, err_timeout}, 32'h0);
    chk("t6_bus_addr", bus_addr, 32'h0);
    chk("t6_bus_we", 32'(bus_we), 32'h0);
    memread = 1'b0;
    #1;
    chk("t6_stall", 32'(stall), 32'h0);
    m_rdata = '0; m_ea = 1'b0; m_et = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    run_instr(1'b1, 1'b0, 32'h0000_0304, 32'h0, 2, 32'h600D_CAFE);
    chk("t6_reload", rdata, 32'h600D_CAFE);

    memread = 1'b0; memwrite = 1'b0; bus_ack = 1'b0;
    @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
